// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST controller and its RAM.
package ram_bist_pkg;

    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_DW = 32;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdIssue,
        StDrain,
        StDone
    } bist_state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // An all-zero seed would lock the LFSR up.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR pattern source; load has priority over step.
module bist_lfsr32
    import ram_bist_pkg::*;
#(
    parameter logic [31:0] RST_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= fix_seed(RST_SEED);
        end else if (load) begin
            value <= fix_seed(seed);
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: seeded LFSR fill, read-back compare, pass/error reporting.
// Define BIST_INV_PASS_EN to add a second fill/compare pass with inverted data.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned AW     = RAM_AW,
    parameter int unsigned DW     = RAM_DW,
    parameter int unsigned RD_LAT = 1,
    parameter logic [31:0] SEED   = 32'h1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_fail_addr,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] Din,
    output logic          RW,
    input  logic [DW-1:0] Dout
);

    localparam logic [AW-1:0] ADDR_MAX = '1;

    bist_state_e   state;
    logic [2:0]    drain_cnt;
    logic [31:0]   lfsr_value;
    logic          lfsr_load;
    logic          lfsr_step;
    logic          start_acc;
    logic          wr_last;
    logic          drain_last;
    logic          last_pass;
    logic          inv;

    logic [RD_LAT-1:0] pipe_vld;
    logic [AW-1:0]     pipe_tag [RD_LAT];

    logic          cmp_vld;
    logic [DW-1:0] pattern;
    logic          mismatch;
    logic [AW:0]   err_next;

    assign start_acc  = start && (state == StIdle || state == StDone);
    assign wr_last    = (state == StWrite) && (addr == ADDR_MAX);
    assign drain_last = (state == StDrain) && (drain_cnt == 3'(RD_LAT - 1));

`ifdef BIST_INV_PASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (start_acc) begin
            inv <= 1'b0;
        end else if (drain_last) begin
            inv <= 1'b1;
        end
    end
    assign last_pass = inv;
`else
    assign inv       = 1'b0;
    assign last_pass = 1'b1;
`endif

    // Both phases replay the same seed so the read side regenerates the fill data.
    assign lfsr_load = start_acc || wr_last || (drain_last && !last_pass);
    assign lfsr_step = (state == StWrite) || cmp_vld;

    bist_lfsr32 #(
        .RST_SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (SEED),
        .step (lfsr_step),
        .value(lfsr_value)
    );

    assign pattern  = inv ? ~lfsr_value[DW-1:0] : lfsr_value[DW-1:0];
    assign Din      = RW ? pattern : '0;
    assign cmp_vld  = pipe_vld[RD_LAT-1];
    assign mismatch = cmp_vld && (Dout != pattern);
    assign err_next = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

    // Address tags ride alongside the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= (state == StRdIssue);
            pipe_tag[0] <= addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            drain_cnt       <= '0;
            addr            <= '0;
            RW              <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
        end else begin
            err_count <= err_next;
            if (mismatch && err_count == '0) first_fail_addr <= pipe_tag[RD_LAT-1];

            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state           <= StWrite;
                        addr            <= '0;
                        RW              <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                    end
                end
                StWrite: begin
                    addr <= addr + 1'b1;
                    if (wr_last) begin
                        RW    <= 1'b0;
                        state <= StRdIssue;
                    end
                end
                StRdIssue: begin
                    addr <= addr + 1'b1;
                    if (addr == ADDR_MAX) begin
                        state     <= StDrain;
                        drain_cnt <= '0;
                    end
                end
                StDrain: begin
                    if (!drain_last) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end else if (!last_pass) begin
                        state <= StWrite;
                        addr  <= '0;
                        RW    <= 1'b1;
                    end else begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench: two controllers (RD_LAT=1/SEED=1 and RD_LAT=3/SEED=0) on behavioral RAMs.
module tb_ram_bist_ctrl;
    import ram_bist_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic          start_a = 1'b0, busy_a, done_a, pass_a, rw_a;
    logic [AW:0]   errc_a;
    logic [AW-1:0] ffa_a, addr_a;
    logic [DW-1:0] din_a, dout_a;

    logic          start_b = 1'b0, busy_b, done_b, pass_b, rw_b;
    logic [AW:0]   errc_b;
    logic [AW-1:0] ffa_b, addr_b;
    logic [DW-1:0] din_b, dout_b;

    ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1), .SEED(32'h1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(errc_a), .first_fail_addr(ffa_a), .addr(addr_a), .Din(din_a), .RW(rw_a),
        .Dout(dout_a)
    );

    ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(3), .SEED(32'h0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(errc_b), .first_fail_addr(ffa_b), .addr(addr_b), .Din(din_b), .RW(rw_b),
        .Dout(dout_b)
    );

    // RAM A: latency 1, optional read corruption at up to two addresses.
    logic [DW-1:0] mem_a [DEPTH];
    logic          flt_en0 = 1'b0, flt_en1 = 1'b0;
    logic [AW-1:0] flt_addr0 = '0, flt_addr1 = '0;
    logic [DW-1:0] flt_mask = '0;
    always @(posedge clk) begin
        if (rw_a) mem_a[addr_a] <= din_a;
        dout_a <= mem_a[addr_a] ^
                  (((flt_en0 && addr_a == flt_addr0) || (flt_en1 && addr_a == flt_addr1)) ?
                   flt_mask : '0);
    end

    // RAM B: latency 3, fault-free.
    logic [DW-1:0] mem_b [DEPTH];
    logic [DW-1:0] rdp_b [3];
    always @(posedge clk) begin
        if (rw_b) mem_b[addr_b] <= din_b;
        rdp_b[0] <= mem_b[addr_b];
        rdp_b[1] <= rdp_b[0];
        rdp_b[2] <= rdp_b[1];
    end
    assign dout_b = rdp_b[2];

    function automatic logic [31:0] tb_lfsr_step(input logic [31:0] v);
        logic [31:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 32'h80200003;
        return s;
    endfunction

    // Write-stream monitor: every write phase must be addr 0..255 with the seed-1 sequence.
    logic          mon_clr   = 1'b0;
    logic          prev_rw_a = 1'b0;
    logic          prev_rw_b = 1'b0;
    logic [31:0]   lf_a      = 32'h0;
    logic [AW:0]   wr_idx_a  = '0;
    int            wr_cnt_a  = 0;
    int            wr_bad_a  = 0;
    logic [DW-1:0] first_din_b = '0;
    logic          got_b     = 1'b0;
    wire  [31:0]   lf_cur_a  = prev_rw_a ? lf_a : 32'h1;
    wire  [AW:0]   idx_cur_a = prev_rw_a ? wr_idx_a : '0;

    always @(negedge clk) begin
        prev_rw_a <= rw_a;
        prev_rw_b <= rw_b;
        if (mon_clr) begin
            wr_cnt_a <= 0;
            wr_bad_a <= 0;
            got_b    <= 1'b0;
        end else begin
            if (rw_a) begin
                wr_cnt_a <= wr_cnt_a + 1;
                lf_a     <= tb_lfsr_step(lf_cur_a);
                wr_idx_a <= idx_cur_a + 1'b1;
                if (din_a !== lf_cur_a[DW-1:0] || {1'b0, addr_a} !== idx_cur_a)
                    wr_bad_a <= wr_bad_a + 1;
            end
            if (rw_b && !prev_rw_b && !got_b) begin
                first_din_b <= din_b;
                got_b       <= 1'b1;
            end
        end
    end

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Returns the cycle offset from the start edge at which done is first high, -1 on timeout.
    task automatic wait_done(input bit sel_b, output int cyc);
        cyc = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (sel_b ? done_b : done_a) begin
                cyc = n + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_a, done_a, pass_a, errc_a, ffa_a} !== '0) begin
            n_errors++;
            $display("FAIL reset_status_a: got %0h required 0", {busy_a, done_a, pass_a, errc_a, ffa_a});
        end
        n_checks++;
        if ({addr_a, din_a, rw_a} !== '0) begin
            n_errors++;
            $display("FAIL reset_ram_if_a: got %0h required 0", {addr_a, din_a, rw_a});
        end
        n_checks++;
        if ({busy_b, done_b, pass_b, errc_b, ffa_b, addr_b, din_b, rw_b} !== '0) begin
            n_errors++;
            $display("FAIL reset_all_b: got %0h required 0",
                     {busy_b, done_b, pass_b, errc_b, ffa_b, addr_b, din_b, rw_b});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_a, done_a} !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy/done %b required 00", {busy_a, done_a});
        end
    endtask

    task automatic test_clean_run();
        int cyc;
        clear_monitor();
        pulse_start(1'b0);
        n_checks++;
        if ({busy_a, rw_a, addr_a, din_a} !== {1'b1, 1'b1, 8'h00, 32'h1}) begin
            n_errors++;
            $display("FAIL first_write: got busy=%b rw=%b addr=%0h din=%0h required 1 1 0 1",
                     busy_a, rw_a, addr_a, din_a);
        end
        wait_done(1'b0, cyc);
        n_checks++;
        if (cyc != 514) begin
            n_errors++;
            $display("FAIL clean_done_cycle: got k+%0d required k+514", cyc);
        end
        n_checks++;
        if (wr_cnt_a != 256 || wr_bad_a != 0) begin
            n_errors++;
            $display("FAIL clean_writes: got %0d writes %0d bad required 256 writes 0 bad",
                     wr_cnt_a, wr_bad_a);
        end
        n_checks++;
        if ({pass_a, busy_a, errc_a, ffa_a} !== {1'b1, 1'b0, 9'd0, 8'h00}) begin
            n_errors++;
            $display("FAIL clean_result: got pass=%b busy=%b err=%0d ffa=%0h required 1 0 0 0",
                     pass_a, busy_a, errc_a, ffa_a);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({done_a, pass_a, rw_a} !== 3'b110) begin
            n_errors++;
            $display("FAIL done_hold: got done/pass/rw %b required 110", {done_a, pass_a, rw_a});
        end
    endtask

    task automatic test_single_fault();
        int cyc;
        flt_en0   = 1'b1;
        flt_addr0 = 8'h10;
        flt_mask  = 32'h0000_0020;
        pulse_start(1'b0);
        wait_done(1'b0, cyc);
        n_checks++;
        if (cyc != 514) begin
            n_errors++;
            $display("FAIL fault1_done_cycle: got k+%0d required k+514", cyc);
        end
        n_checks++;
        if ({pass_a, errc_a, ffa_a} !== {1'b0, 9'd1, 8'h10}) begin
            n_errors++;
            $display("FAIL fault1_result: got pass=%b err=%0d ffa=%0h required 0 1 10",
                     pass_a, errc_a, ffa_a);
        end
    endtask

    task automatic test_double_fault();
        int cyc;
        flt_en0   = 1'b1;
        flt_addr0 = 8'h03;
        flt_en1   = 1'b1;
        flt_addr1 = 8'hF0;
        flt_mask  = 32'h8000_0001;
        pulse_start(1'b0);
        n_checks++;
        if ({done_a, busy_a, errc_a, ffa_a} !== {1'b0, 1'b1, 9'd0, 8'h00}) begin
            n_errors++;
            $display("FAIL restart_clear: got done=%b busy=%b err=%0d ffa=%0h required 0 1 0 0",
                     done_a, busy_a, errc_a, ffa_a);
        end
        wait_done(1'b0, cyc);
        n_checks++;
        if ({pass_a, errc_a, ffa_a} !== {1'b0, 9'd2, 8'h03}) begin
            n_errors++;
            $display("FAIL fault2_result: got pass=%b err=%0d ffa=%0h required 0 2 3",
                     pass_a, errc_a, ffa_a);
        end
        flt_en0 = 1'b0;
        flt_en1 = 1'b0;
    endtask

    task automatic test_mid_run_reset();
        int cyc;
        bit found;
        found = 1'b0;
        pulse_start(1'b0);
        for (int n = 0; n < 300; n++) begin
            if (rw_a && addr_a == 8'h40) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reach_addr40: got no write at 40 required one");
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_a, done_a, pass_a, errc_a, ffa_a, addr_a, din_a, rw_a} !== '0) begin
            n_errors++;
            $display("FAIL async_reset_outputs: got %0h required 0",
                     {busy_a, done_a, pass_a, errc_a, ffa_a, addr_a, din_a, rw_a});
        end
        n_checks++;
        if (dut_a.state !== StIdle) begin
            n_errors++;
            $display("FAIL async_reset_state: got %0d required %0d", dut_a.state, StIdle);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_monitor();
        pulse_start(1'b0);
        wait_done(1'b0, cyc);
        n_checks++;
        if (cyc != 514 || pass_a !== 1'b1 || wr_cnt_a != 256 || wr_bad_a != 0) begin
            n_errors++;
            $display("FAIL rerun_after_reset: got cyc=%0d pass=%b writes=%0d bad=%0d required 514 1 256 0",
                     cyc, pass_a, wr_cnt_a, wr_bad_a);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        cyc = -1;
        pulse_start(1'b0);
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (n == 94) start_a = 1'b1;
            if (n == 95) start_a = 1'b0;
            if (done_a) begin
                cyc = n + 1;
                break;
            end
        end
        n_checks++;
        if (cyc != 514) begin
            n_errors++;
            $display("FAIL busy_start_done_cycle: got k+%0d required k+514", cyc);
        end
        n_checks++;
        if ({pass_a, errc_a} !== {1'b1, 9'd0}) begin
            n_errors++;
            $display("FAIL busy_start_result: got pass=%b err=%0d required 1 0", pass_a, errc_a);
        end
    endtask

    task automatic test_lat3_seed0();
        int cyc;
        clear_monitor();
        pulse_start(1'b1);
        n_checks++;
        if ({rw_b, addr_b, din_b} !== {1'b1, 8'h00, 32'h0000_0001}) begin
            n_errors++;
            $display("FAIL lat3_first_write: got rw=%b addr=%0h din=%0h required 1 0 1",
                     rw_b, addr_b, din_b);
        end
        wait_done(1'b1, cyc);
        n_checks++;
        if (cyc != 516) begin
            n_errors++;
            $display("FAIL lat3_done_cycle: got k+%0d required k+516", cyc);
        end
        n_checks++;
        if ({pass_b, errc_b, ffa_b} !== {1'b1, 9'd0, 8'h00}) begin
            n_errors++;
            $display("FAIL lat3_result: got pass=%b err=%0d ffa=%0h required 1 0 0",
                     pass_b, errc_b, ffa_b);
        end
        n_checks++;
        if (!got_b || first_din_b !== 32'h0000_0001) begin
            n_errors++;
            $display("FAIL lat3_seed_fix: got %0h required 1", first_din_b);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_fault();
        test_double_fault();
        test_mid_run_reset();
        test_start_while_busy();
        test_lat3_seed0();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Synthesizable initiator for the 256x32 single-port RAM interface (addr, Din, Dout, RW, clk).
- Fills every word with a seeded pseudo-random pattern, then reads every word back and compares it against a regenerated pattern.
- Reports pass/fail, the error count and the first failing address.
- Sits between the system start logic and the RAM as its sole master during test.

Parameters:
- AW, 8, RAM address width; depth = 2**AW.
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in clocks (addr presented to Dout valid); legal range 1..4.
- SEED, 32'h1, LFSR seed; a value of 0 is replaced by 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  high in DONE; held until the next accepted start.
- pass  output  1  valid while done; 1 = zero mismatches.
- err_count  output  AW+1  saturating mismatch count.
- first_fail_addr  output  AW  address of the first mismatch; 0 if none.
- addr  output  AW  RAM address.
- Din  output  DW  RAM write data.
- RW  output  1  1 = write, 0 = read.
- Dout  input  DW  RAM read data.

Behaviour:
- Reset (async, any time, including mid-run):
  - State returns to IDLE.
  - addr, Din, RW, busy, done, pass, err_count and first_fail_addr are all 0.
  - LFSR reloads SEED.
- LFSR: 32-bit Galois, taps 32'h80200003 (x^32+x^22+x^2+x+1). It advances once per write issue and once per read compare. Din takes the low DW bits.
- States: IDLE, WRITE, RD_ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 at edge k → WRITE.
  - err_count and first_fail_addr are cleared, and the LFSR loads SEED.
- WRITE:
  - Cycles k+1 .. k+2**AW.
  - RW=1, addr=0..2**AW-1 incrementing, Din = current LFSR value.
  - After addr=max: LFSR reloads SEED, addr wraps to 0, state → RD_ISSUE.
- RD_ISSUE:
  - One read address per cycle, 0..max, RW=0.
  - A valid/expected shift pipe of depth RD_LAT delays the address tag.
  - Dout is compared RD_LAT cycles after its address was issued.
  - The LFSR advances on each compare, not on each issue.
- DRAIN:
  - Entered after the last issue.
  - Lasts RD_LAT cycles, completing the outstanding compares.
  - Then → DONE.
- DONE:
  - done=1, busy=0.
  - pass = (err_count==0).
  - start → a new run (same sequence as from IDLE); otherwise holds.
- Mismatch:
  - err_count increments, saturating at 2**(AW+1)-1.
  - On the first mismatch only, first_fail_addr captures the pipelined address tag.
- Cycle budget: done first high at cycle k + 2·2**AW + RD_LAT + 1. For the defaults that is k+514.
- start while busy is ignored.
- RW is driven 0 in every state except WRITE, so the RAM is never written outside the fill phase.

Optional Feature:
- Macro BIST_INV_PASS_EN.
- When defined, after the first read pass a second WRITE + RD_ISSUE + DRAIN sequence runs with data = ~LFSR (same seed replay).
  - This ensures every bit is tested at both polarities.
  - err_count and first_fail_addr accumulate across both passes.
  - done is delayed to k + 4·2**AW + 2·RD_LAT + 1.
- When not defined, a single pass runs with no extra logic and no extra state.

Decomposition:
- Shared package ram_bist_pkg:
  - state enum encoding.
  - LFSR_TAPS = 32'h80200003.
  - default AW/DW constants shared with the RAM.
- Natural sub-module: bist_lfsr32, with ports clk, rst, load, seed, step, value. It is instantiated once and reloaded for the read phase.

Test Plan:
- Fault-free behavioral RAM, RD_LAT=1, start at cycle 5:
  - Expect busy from cycle 6.
  - Expect 256 writes.
  - Expect done=1 at cycle 519.
  - Expect pass=1, err_count=0, first_fail_addr=0.
- RAM model XORs Dout[5] at address 8'h10:
  - Expect pass=0, err_count=1, first_fail_addr=8'h10.
- RAM model corrupts addresses 8'h03 and 8'hF0:
  - Expect err_count=2, first_fail_addr=8'h03.
- rst asserted at write address 8'h40:
  - All outputs 0 asynchronously; RW=0; state IDLE.
  - A subsequent start completes with pass=1.
- start pulsed again while busy at cycle 100: ignored, and the done cycle is unchanged.
- Rebuild with RD_LAT=3 and SEED=0:
  - Expect done at k+516 and pass=1.
  - Expect first write Din = 32'h00000001.
